spi_shift_engine: RTL and testbench
===================================

// Module: spi_shift_engine
// PURPOSE
//  Serial data path of the SPI master, directly downstream of spi_clgen. Consumes the
//  clgen edge strobes (cpol_0 = pos_edge, cpol_1 = neg_edge), shifts a tx character out
//  on mosi_o and samples miso_i into an rx register. Drives tip and last_clk back to
//  spi_clgen, which ends sclk generation after the final bit.
// PARAMETERS
//  MAX_CHAR       128  max character length in bits; width of tx_data/rx_data
//  CHAR_LEN_BITS  7    width of len; len==0 encodes MAX_CHAR bits
// PORTS
//  wb_clk_in   in   1              system clock; all logic on posedge
//  wb_rst      in   1              synchronous, active-high reset
//  go          in   1              start request; acted on only when tip==0
//  len         in   CHAR_LEN_BITS  char length in bits (0 => MAX_CHAR)
//  lsb         in   1              1: LSB first, 0: MSB first
//  tx_negedge  in   1              1: drive mosi on neg_edge, 0: on pos_edge
//  rx_negedge  in   1              1: sample miso on neg_edge, 0: on pos_edge
//  tx_load     in   1              load tx_data into shift reg; ignored while tip==1
//  tx_data     in   MAX_CHAR       parallel tx character
//  pos_edge    in   1              from spi_clgen cpol_0, one-cycle strobe
//  neg_edge    in   1              from spi_clgen cpol_1, one-cycle strobe
//  miso_i      in   1              serial input
//  mosi_o      out  1              serial output
//  tip         out  1              transfer in progress (to spi_clgen)
//  last_clk    out  1              all bits driven (to spi_clgen)
//  done        out  1              one-cycle pulse when transfer completes
//  rx_data     out  MAX_CHAR       received character; stable while tip==0
// BEHAVIOUR
//  - Reset (sync, any time, incl. mid-transfer): tip=0, last_clk=0, done=0, mosi_o=0,
//    rx_data=0, tx shift reg=0, tx_cnt=rx_cnt=0, latched mode=0. No done pulse on abort.
//  - N = (len==0) ? MAX_CHAR : len. go with tip==0: latch N, lsb, tx_negedge,
//    rx_negedge; clear tx_cnt/rx_cnt; tip=1 next cycle. go while tip==1 ignored.
//  - Mode inputs changed during a transfer have no effect (latched copy used).
//  - tx_load && !tip: shift reg <= tx_data. tx_load && go same cycle: load takes
//    effect first, go starts with the new data.
//  - tx edge = latched tx_negedge ? neg_edge : pos_edge. On tx edge with tip &&
//    tx_cnt<N: mosi_o <= txreg[lsb ? tx_cnt : N-1-tx_cnt]; tx_cnt++. Further tx
//    edges once tx_cnt==N ignored. mosi_o holds last value when idle.
//  - last_clk = tip && (tx_cnt==N) (combinational from registers).
//  - rx edge = latched rx_negedge ? neg_edge : pos_edge. On rx edge with tip:
//    rx_data[lsb ? rx_cnt : N-1-rx_cnt] <= miso_i; rx_cnt++. If rx_cnt==N-1 at that
//    edge: tip<=0, done<=1 for exactly one cycle. Bits of rx_data at index>=N keep
//    prior values.
//  - tx and rx edges in the same cycle are both processed independently.
//  - Index arithmetic on $clog2(MAX_CHAR)+1-bit counters; no wrap (bounded by N).
//  - States: IDLE (tip=0) -> SHIFT (tip=1) on go; SHIFT -> IDLE on final rx sample
//    or wb_rst. Latency go -> tip = 1 cycle; final rx edge -> done/tip=0 = 1 cycle.
// STRUCTURE
//  - spi_defines.v holds SPI_MAX_CHAR, SPI_CHAR_LEN_BITS defaults; parameters
//    default to those macros.
//  - One sub-module natural: spi_bit_index (N, cnt, lsb -> bit index), shared by
//    tx and rx paths.
// TESTING
//  - wb_rst held mid-transfer (tip=1, tx_cnt=3) -> next cycle tip=0, mosi_o=0,
//    rx_data=0, done stays 0.
//  - len=8, lsb=0, tx_negedge=1, rx_negedge=0, tx_data=8'hA5, miso_i looped to mosi_o
//    -> mosi_o sequence 1,0,1,0,0,1,0,1; rx_data[7:0]=8'hA5; one done pulse.
//  - len=8, lsb=1, tx_data=8'h01, miso_i=1 constant -> first mosi bit 1 then seven 0s;
//    rx_data[7:0]=8'hFF, rx_data[127:8] unchanged.
//  - len=0 (128 bits), alternating pos/neg strobes from spi_clgen divider=0 -> exactly
//    128 tx edges counted, last_clk rises after 128th, tip falls after 128th rx sample.
//  - go and tx_load pulsed during tip=1 with new tx_data -> ignored; transfer data and
//    length unchanged; len changed mid-transfer from 8 to 4 -> still 8 bits.
//  - Both tx/rx on pos_edge, len=1 -> tx and rx processed same cycle; done one cycle
//    after that edge; tip=1 for exactly go+1 .. edge cycle.

Source files
------------

// File: rtl/spi_shift_engine_pkg.sv
// Shared constants and types for the SPI serial shift engine.
package spi_shift_engine_pkg;

  // Default character geometry: up to 128-bit characters, 7-bit length field.
  localparam int SPI_MAX_CHAR      = 128;
  localparam int SPI_CHAR_LEN_BITS = 7;

  // Engine states. tip is simply "state == ST_SHIFT".
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Mode bits captured at the start of a transfer.
  typedef struct packed {
    logic lsb;
    logic tx_negedge;
    logic rx_negedge;
  } spi_mode_t;

endpackage

// File: rtl/spi_bit_index.sv
// Maps a shift counter to a character bit position.
// LSB-first walks 0..N-1; MSB-first walks N-1..0. Arithmetic is modulo
// 2**IDX_W, so N == MAX_CHAR (encoded as 0 in the low bits) still yields
// MAX_CHAR-1-cnt.
module spi_bit_index #(
  parameter int IDX_W = 7
) (
  input  logic [IDX_W-1:0] n,
  input  logic [IDX_W-1:0] cnt,
  input  logic             lsb,
  output logic [IDX_W-1:0] idx
);

  // Pick counter directly or mirror it around N-1.
  always_comb begin
    idx = lsb ? cnt : (n - IDX_W'(1) - cnt);
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master serial data path: shifts a tx character out on mosi_o and
// samples miso_i into rx_data, paced by the spi_clgen edge strobes.
//
// Start handshake: go is a request qualified by tip. A go seen while tip==0
// is accepted on that clock edge (mode and length latched, tip high on the
// next cycle); a go seen while tip==1 is dropped, never queued. done pulses
// for one cycle in the cycle where tip has just returned to 0.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int MAX_CHAR      = SPI_MAX_CHAR,
  parameter int CHAR_LEN_BITS = SPI_CHAR_LEN_BITS
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     tx_negedge,
  input  logic                     rx_negedge,
  input  logic                     tx_load,
  input  logic [MAX_CHAR-1:0]      tx_data,
  input  logic                     pos_edge,
  input  logic                     neg_edge,
  input  logic                     miso_i,
  output logic                     mosi_o,
  output logic                     tip,
  output logic                     last_clk,
  output logic                     done,
  output logic [MAX_CHAR-1:0]      rx_data
);

  localparam int IDX_W = $clog2(MAX_CHAR);
  localparam int CNT_W = IDX_W + 1;

  logic [0:0]          state;
  spi_mode_t           mode;
  logic [CNT_W-1:0]    n_lat;
  logic [CNT_W-1:0]    n_next;
  logic [CNT_W-1:0]    tx_cnt;
  logic [CNT_W-1:0]    rx_cnt;
  logic [MAX_CHAR-1:0] txreg;
  logic [IDX_W-1:0]    tx_idx;
  logic [IDX_W-1:0]    rx_idx;
  logic                tx_edge;
  logic                rx_edge;
  logic                start;
  logic                rx_final;

  // Decode length, edge selection and start/finish conditions.
  always_comb begin
    n_next   = (len == '0) ? CNT_W'(MAX_CHAR) : CNT_W'(len);
    tx_edge  = mode.tx_negedge ? neg_edge : pos_edge;
    rx_edge  = mode.rx_negedge ? neg_edge : pos_edge;
    start    = (state == ST_IDLE) && go;
    rx_final = (state == ST_SHIFT) && rx_edge && (rx_cnt == n_lat - CNT_W'(1));
    tip      = (state == ST_SHIFT);
    last_clk = (state == ST_SHIFT) && (tx_cnt == n_lat);
  end

  spi_bit_index #(.IDX_W(IDX_W)) u_tx_index (
    .n   (n_lat[IDX_W-1:0]),
    .cnt (tx_cnt[IDX_W-1:0]),
    .lsb (mode.lsb),
    .idx (tx_idx)
  );

  spi_bit_index #(.IDX_W(IDX_W)) u_rx_index (
    .n   (n_lat[IDX_W-1:0]),
    .cnt (rx_cnt[IDX_W-1:0]),
    .lsb (mode.lsb),
    .idx (rx_idx)
  );

  // Transfer FSM: IDLE -> SHIFT on go, SHIFT -> IDLE on the final rx sample.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rx_final) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture length and mode at start so mid-transfer input changes are inert.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      n_lat <= '0;
      mode  <= '0;
    end else if (start) begin
      n_lat <= n_next;
      mode  <= '{lsb: lsb, tx_negedge: tx_negedge, rx_negedge: rx_negedge};
    end
  end

  // Tx path: parallel load while idle, then one bit per tx edge until N sent.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      txreg  <= '0;
      tx_cnt <= '0;
      mosi_o <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (tx_load) txreg  <= tx_data;
      if (go)      tx_cnt <= '0;
    end else if (tx_edge && (tx_cnt != n_lat)) begin
      mosi_o <= txreg[tx_idx];
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  // Rx path: one sample per rx edge; bits at index >= N are never touched.
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      rx_data <= '0;
      rx_cnt  <= '0;
    end else if (start) begin
      rx_cnt <= '0;
    end else if ((state == ST_SHIFT) && rx_edge) begin
      rx_data[rx_idx] <= miso_i;
      rx_cnt          <= rx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with hand-derived expectations.
module tb_spi_shift_engine;

  localparam int W = 128;

  // Clock and reset
  logic clk = 1'b0;
  logic wb_rst;
  always #5 clk = ~clk;

  // Stimulus and DUT outputs
  logic         go, lsb, tx_negedge, rx_negedge, tx_load, pos_edge, neg_edge;
  logic         miso_drv, loop_en;
  logic [6:0]   len;
  logic [W-1:0] tx_data;
  logic         miso_i;
  logic         mosi_o, tip, last_clk, done;
  logic [W-1:0] rx_data;

  assign miso_i = loop_en ? mosi_o : miso_drv;

  spi_shift_engine dut (
    .wb_clk_in  (clk),
    .wb_rst     (wb_rst),
    .go         (go),
    .len        (len),
    .lsb        (lsb),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .tx_load    (tx_load),
    .tx_data    (tx_data),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .miso_i     (miso_i),
    .mosi_o     (mosi_o),
    .tip        (tip),
    .last_clk   (last_clk),
    .done       (done),
    .rx_data    (rx_data)
  );

  // Scoreboard counters
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int dc0;
  logic [W-1:0] mosi_seq;
  logic [W-1:0] pat;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe on pos_edge and/or neg_edge.
  task automatic strobe(input logic p, input logic n);
    pos_edge = p;
    neg_edge = n;
    tick();
    pos_edge = 1'b0;
    neg_edge = 1'b0;
  endtask

  // Load + go in the same cycle, then confirm tip rose one cycle later.
  task automatic start(input logic [6:0] l, input logic lsb_f, input logic txn,
                       input logic rxn, input logic [W-1:0] d);
    len = l; lsb = lsb_f; tx_negedge = txn; rx_negedge = rxn;
    tx_data = d; tx_load = 1'b1; go = 1'b1;
    tick();
    tx_load = 1'b0; go = 1'b0;
    check("tip_start", W'(tip), W'(1'b1));
    check("last_clk_start", W'(last_clk), W'(1'b0));
    mosi_seq = '0;
    dc0 = done_cnt;
  endtask

  // One bit: tx strobe then rx strobe on the opposite clgen edge.
  task automatic one_bit(input int i, input int n, input logic tx_on_neg, input logic rx_on_neg);
    strobe(!tx_on_neg, tx_on_neg);
    mosi_seq[7'(i)] = mosi_o;
    check("last_clk", W'(last_clk), W'(i == n - 1));
    strobe(!rx_on_neg, rx_on_neg);
    check("tip_bit", W'(tip), W'(i != n - 1));
    check("done_bit", W'(done), W'(i == n - 1));
  endtask

  // Expected mosi order: element i is the bit sent on the i-th tx edge.
  function automatic logic [W-1:0] exp_seq(input logic [W-1:0] d, input int n, input logic l);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[7'(i)] = l ? d[7'(i)] : d[7'(n - 1 - i)];
    return r;
  endfunction

  initial begin
    go = 0; lsb = 0; tx_negedge = 0; rx_negedge = 0; tx_load = 0;
    pos_edge = 0; neg_edge = 0; miso_drv = 0; loop_en = 0;
    len = '0; tx_data = '0; mosi_seq = '0; dc0 = 0;
    pat = {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hF0E1D2C3};

    // Reset state
    wb_rst = 1'b1;
    tick(); tick();
    check("rst_tip", W'(tip), W'(1'b0));
    check("rst_last_clk", W'(last_clk), W'(1'b0));
    check("rst_done", W'(done), W'(1'b0));
    check("rst_mosi", W'(mosi_o), W'(1'b0));
    check("rst_rx", rx_data, '0);
    wb_rst = 1'b0;
    tick();

    // 8-bit MSB-first loopback of A5, tx on neg, rx on pos
    loop_en = 1'b1;
    start(7'd8, 1'b0, 1'b1, 1'b0, W'(8'hA5));
    for (int i = 0; i < 8; i++) one_bit(i, 8, 1'b1, 1'b0);
    tick();
    check("a5_done_low", W'(done), W'(1'b0));
    check("a5_mosi_seq", mosi_seq, W'(8'b10100101));
    check("a5_rx", rx_data, W'(8'hA5));
    check("a5_done_cnt", W'(done_cnt - dc0), W'(1));

    // 128-bit LSB-first loopback, alternating strobes every cycle
    start(7'd0, 1'b1, 1'b1, 1'b0, pat);
    for (int i = 0; i < 128; i++) one_bit(i, 128, 1'b1, 1'b0);
    tick();
    check("c128_mosi_seq", mosi_seq, exp_seq(pat, 128, 1'b1));
    check("c128_rx", rx_data, pat);
    check("c128_done_cnt", W'(done_cnt - dc0), W'(1));
    strobe(1'b0, 1'b1);
    check("c128_idle_mosi_hold", W'(mosi_o), W'(pat[127]));

    // 8-bit LSB-first, tx on pos, rx on neg, miso tied high
    loop_en = 1'b0;
    miso_drv = 1'b1;
    start(7'd8, 1'b1, 1'b0, 1'b1, W'(8'h01));
    for (int i = 0; i < 8; i++) one_bit(i, 8, 1'b0, 1'b1);
    tick();
    check("lsb_mosi_seq", mosi_seq, W'(8'h01));
    check("lsb_rx", rx_data, {pat[127:8], 8'hFF});
    check("lsb_done_cnt", W'(done_cnt - dc0), W'(1));

    // Mid-transfer go/tx_load/mode/len changes are ignored
    loop_en = 1'b1;
    start(7'd8, 1'b0, 1'b1, 1'b0, W'(8'h3C));
    for (int i = 0; i < 2; i++) one_bit(i, 8, 1'b1, 1'b0);
    go = 1'b1; tx_load = 1'b1; tx_data = '1; len = 7'd4;
    lsb = 1'b1; tx_negedge = 1'b0; rx_negedge = 1'b1;
    tick();
    go = 1'b0; tx_load = 1'b0;
    check("mid_tip", W'(tip), W'(1'b1));
    for (int i = 2; i < 8; i++) one_bit(i, 8, 1'b1, 1'b0);
    tick();
    check("mid_mosi_seq", mosi_seq, exp_seq(W'(8'h3C), 8, 1'b0));
    check("mid_rx", rx_data, {pat[127:8], 8'h3C});
    check("mid_done_cnt", W'(done_cnt - dc0), W'(1));

    // Reset mid-transfer after three tx edges
    start(7'd8, 1'b0, 1'b1, 1'b0, W'(8'hFF));
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1);
    check("abort_pre_mosi", W'(mosi_o), W'(1'b1));
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    check("abort_tip", W'(tip), W'(1'b0));
    check("abort_mosi", W'(mosi_o), W'(1'b0));
    check("abort_rx", rx_data, '0);
    check("abort_done", W'(done), W'(1'b0));
    check("abort_last_clk", W'(last_clk), W'(1'b0));
    tick();
    check("abort_done_cnt", W'(done_cnt - dc0), W'(0));

    // len=1 with tx and rx on the same pos_edge strobe
    loop_en = 1'b0;
    miso_drv = 1'b1;
    start(7'd1, 1'b0, 1'b0, 1'b0, W'(1'b1));
    tick();
    check("one_wait_tip", W'(tip), W'(1'b1));
    check("one_wait_done", W'(done), W'(1'b0));
    strobe(1'b1, 1'b0);
    check("one_mosi", W'(mosi_o), W'(1'b1));
    check("one_tip", W'(tip), W'(1'b0));
    check("one_done", W'(done), W'(1'b1));
    check("one_rx", rx_data, W'(1'b1));
    tick();
    check("one_done_low", W'(done), W'(1'b0));
    check("one_done_cnt", W'(done_cnt - dc0), W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
